// File: rtl/int_sched_pkg.sv
// Shared definitions for the raster interrupt scheduler: register map,
// default frame height and the line scheduler state type.
package int_sched_pkg;

  localparam logic [2:0] INTSCH_VSINTL = 3'd0;
  localparam logic [2:0] INTSCH_VSINTH = 3'd1;
  localparam logic [2:0] INTSCH_HSINT  = 3'd2;
  localparam logic [2:0] INTSCH_LBASEL = 3'd3;
  localparam logic [2:0] INTSCH_LBASEH = 3'd4;
  localparam logic [2:0] INTSCH_LSTEP  = 3'd5;

  localparam int INTSCH_VLINES = 320;

  typedef struct packed {
    logic [8:0] vsint;
    logic [7:0] hsint;
    logic [8:0] lbase;
    logic [7:0] lstep;
  } intsch_cfg_t;

  typedef enum logic {
    LS_IDLE  = 1'b0,
    LS_ARMED = 1'b1
  } ls_state_t;

endpackage

// File: rtl/int_line_step.sv
// Line INT scheduler: fires on the base line, then every lstep+1 lines
// until the end of the frame. Evaluated only on line_start cycles.
module int_line_step
  import int_sched_pkg::*;
#(
  parameter int VLINES = INTSCH_VLINES,
  parameter int HW     = 9
) (
  input  logic          clk,
  input  logic          res,
  input  logic          line_start,
  input  logic          frame_start,
  input  logic [HW-1:0] vcnt,
  input  logic [8:0]    lbase,
  input  logic [7:0]    lstep,
  output logic          fire
);

  ls_state_t  state_reg, state_next;
  logic [7:0] stepcnt_reg, stepcnt_next;
  logic       fire_reg, fire_next;
  ls_state_t  state_eff;
  logic       base_hit;

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg   <= LS_IDLE;
      stepcnt_reg <= 8'd0;
      fire_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      stepcnt_reg <= stepcnt_next;
      fire_reg    <= fire_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    stepcnt_next = stepcnt_reg;
    fire_next    = 1'b0;
    // A new frame disarms before the base-line rule gets its chance.
    state_eff    = frame_start ? LS_IDLE : state_reg;
    base_hit     = (int'(vcnt) == int'(lbase)) && (int'(lbase) < VLINES);
    if (line_start) begin
      state_next = state_eff;
      if (base_hit) begin
        fire_next    = 1'b1;
        state_next   = LS_ARMED;
        stepcnt_next = lstep;
      end else if (state_eff == LS_ARMED && stepcnt_reg == 8'd0) begin
        fire_next    = 1'b1;
        stepcnt_next = lstep;
      end else if (state_eff == LS_ARMED) begin
        stepcnt_next = stepcnt_reg - 8'd1;
      end
    end
  end

  assign fire = fire_reg;

endmodule

// File: rtl/int_sched.sv
// Raster-position interrupt scheduler: frame INT at a programmed (line, column)
// once per frame, plus the stepped line INT from int_line_step.
module int_sched
  import int_sched_pkg::*;
#(
  parameter int VLINES = INTSCH_VLINES,
  parameter int HW     = 9
) (
  input  logic          clk,
  input  logic          res,
  input  logic [HW-1:0] hcnt,
  input  logic [HW-1:0] vcnt,
  input  logic          line_start,
  input  logic          frame_start,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [7:0]    cfg_data,
  output logic          int_start_frm,
  output logic          int_start_lin,
  output logic          frm_fired
);

  intsch_cfg_t cfg_reg, cfg_next;
  logic        match_reg, fired_reg, int_frm_reg;
  logic        match_prev, fired_prev, fmatch, frm_fire;
  logic        unused_hcnt_lsb;

  assign unused_hcnt_lsb = hcnt[0];

  always_comb begin
    cfg_next = cfg_reg;
    if (cfg_we) begin
      case (cfg_addr)
        INTSCH_VSINTL: cfg_next.vsint[7:0] = cfg_data;
        INTSCH_VSINTH: cfg_next.vsint[8]   = cfg_data[0];
        INTSCH_HSINT:  cfg_next.hsint      = cfg_data;
        INTSCH_LBASEL: cfg_next.lbase[7:0] = cfg_data;
        INTSCH_LBASEH: cfg_next.lbase[8]   = cfg_data[0];
        INTSCH_LSTEP:  cfg_next.lstep      = cfg_data;
        default:       cfg_next = cfg_reg;
      endcase
    end
  end

  // frame_start clears the history first so a (0,0) position refires each frame.
  always_comb begin
    match_prev = frame_start ? 1'b0 : match_reg;
    fired_prev = frame_start ? 1'b0 : fired_reg;
    fmatch     = (int'(vcnt) == int'(cfg_reg.vsint)) &&
                 (int'(cfg_reg.vsint) < VLINES) &&
                 (hcnt[8:1] == cfg_reg.hsint) && !fired_prev;
    frm_fire   = fmatch && !match_prev;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cfg_reg     <= '0;
      match_reg   <= 1'b0;
      fired_reg   <= 1'b0;
      int_frm_reg <= 1'b0;
    end else begin
      cfg_reg     <= cfg_next;
      match_reg   <= fmatch;
      fired_reg   <= fired_prev | frm_fire;
      int_frm_reg <= frm_fire;
    end
  end

  int_line_step #(
    .VLINES(VLINES),
    .HW    (HW)
  ) u_line_step (
    .clk        (clk),
    .res        (res),
    .line_start (line_start),
    .frame_start(frame_start),
    .vcnt       (vcnt),
    .lbase      (cfg_reg.lbase),
    .lstep      (cfg_reg.lstep),
    .fire       (int_start_lin)
  );

  assign int_start_frm = int_frm_reg;
  assign frm_fired     = fired_reg;

endmodule
